// File: rtl/fft_input_packer.sv
// fft_input_packer: collects serial complex <3.6> samples into a ping-pong
// frame buffer. Each completed frame is replayed to the FFT as an unbroken
// burst of FRAME_LEN/NUM beats, with NUM parallel lanes per beat.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   s_valid, s_sof   serial sample valid / start of frame (sof qualified by valid)
//   s_i, s_q         serial signed real / imaginary sample
//   valid_out        beat valid (drives FFT valid_in)
//   dout_i, dout_q   NUM signed lanes per beat; lane l of beat r = sample NUM*r+l
//   blk_idx          row index of the current beat, 0 when idle
//   frame_err        one-cycle pulse when a partial frame is discarded
module fft_input_packer #(
  parameter int unsigned IN_WIDTH  = 9,
  parameter int unsigned NUM       = 16,
  parameter int unsigned FRAME_LEN = 512
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  s_valid,
  input  logic                                  s_sof,
  input  logic signed [IN_WIDTH-1:0]            s_i,
  input  logic signed [IN_WIDTH-1:0]            s_q,
  output logic                                  valid_out,
  output logic signed [IN_WIDTH-1:0]            dout_i [0:NUM-1],
  output logic signed [IN_WIDTH-1:0]            dout_q [0:NUM-1],
  output logic [$clog2(FRAME_LEN/NUM)-1:0]      blk_idx,
  output logic                                  frame_err
);

  localparam int unsigned BLOCKS = FRAME_LEN / NUM;
  localparam int unsigned PTR_W  = $clog2(FRAME_LEN);
  localparam int unsigned LANE_W = $clog2(NUM);
  localparam int unsigned ROW_W  = $clog2(BLOCKS);

  typedef struct packed {
    logic signed [IN_WIDTH-1:0] re;
    logic signed [IN_WIDTH-1:0] im;
  } sample_t;

  typedef enum logic { W_IDLE, W_FILL  } wstate_e;
  typedef enum logic { R_IDLE, R_BURST } rstate_e;

  // Frame storage: bank x row x lane
  sample_t mem_q [2][BLOCKS][NUM];

  wstate_e            wstate_q, wstate_d;
  rstate_e            rstate_q, rstate_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic               wbank_q, wbank_d;
  logic               rbank_q, rbank_d;
  logic [ROW_W-1:0]   rrow_q, rrow_d;
  logic [1:0]         full_q, full_d;
  logic               valid_q, valid_d;
  logic [ROW_W-1:0]   blk_q, blk_d;
  logic               err_q, err_d;
  logic signed [IN_WIDTH-1:0] dout_i_q [NUM];
  logic signed [IN_WIDTH-1:0] dout_q_q [NUM];

  logic               we_c;
  logic [PTR_W-1:0]   waddr_c;
  logic               full_set_c;
  logic               full_clr_c;
  logic               load_c;
  logic [ROW_W-1:0]   rd_row_c;

  // Write FSM next-state: fill wbank sample by sample, restart on sof
  always_comb begin
    wstate_d   = wstate_q;
    wptr_d     = wptr_q;
    wbank_d    = wbank_q;
    we_c       = 1'b0;
    waddr_c    = wptr_q;
    err_d      = 1'b0;
    full_set_c = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        if (s_valid && s_sof) begin
          we_c     = 1'b1;
          waddr_c  = '0;
          wptr_d   = PTR_W'(1);
          wstate_d = W_FILL;
        end
      end
      W_FILL: begin
        if (s_valid && s_sof) begin
          // Restart in the same bank; the partial frame is simply overwritten
          err_d   = 1'b1;
          we_c    = 1'b1;
          waddr_c = '0;
          wptr_d  = PTR_W'(1);
        end else if (s_valid) begin
          we_c = 1'b1;
          if (wptr_q == PTR_W'(FRAME_LEN - 1)) begin
            full_set_c = 1'b1;
            wbank_d    = ~wbank_q;
            wptr_d     = '0;
            wstate_d   = W_IDLE;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read FSM next-state: banks complete in alternating order, so a toggling
  // read pointer always selects the older FULL bank
  always_comb begin
    rstate_d   = rstate_q;
    rrow_d     = rrow_q;
    rbank_d    = rbank_q;
    valid_d    = 1'b0;
    blk_d      = '0;
    load_c     = 1'b0;
    rd_row_c   = rrow_q;
    full_clr_c = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          load_c   = 1'b1;
          rd_row_c = '0;
          valid_d  = 1'b1;
          rrow_d   = ROW_W'(1);
          rstate_d = R_BURST;
        end
      end
      R_BURST: begin
        load_c  = 1'b1;
        valid_d = 1'b1;
        blk_d   = rrow_q;
        if (rrow_q == ROW_W'(BLOCKS - 1)) begin
          full_clr_c = 1'b1;
          rbank_d    = ~rbank_q;
          rrow_d     = '0;
          rstate_d   = R_IDLE;
        end else begin
          rrow_d = rrow_q + 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Bank occupancy flags
  always_comb begin
    full_d = full_q;
    if (full_clr_c) full_d[rbank_q] = 1'b0;
    if (full_set_c) full_d[wbank_q] = 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wptr_q   <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      rrow_q   <= '0;
      full_q   <= '0;
      valid_q  <= 1'b0;
      blk_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wptr_q   <= wptr_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      rrow_q   <= rrow_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      blk_q    <= blk_d;
      err_q    <= err_d;
    end
  end

  // Sample storage write: sample n lands at row n/NUM, lane n%NUM
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[wbank_q][waddr_c[PTR_W-1:LANE_W]][waddr_c[LANE_W-1:0]] <= {s_i, s_q};
    end
  end

  // Output lanes: load one row per beat, hold the last beat when idle
  for (genvar l = 0; l < NUM; l++) begin : g_lane
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_i_q[l] <= '0;
        dout_q_q[l] <= '0;
      end else if (load_c) begin
        dout_i_q[l] <= mem_q[rbank_q][rd_row_c][l].re;
        dout_q_q[l] <= mem_q[rbank_q][rd_row_c][l].im;
      end
    end
    assign dout_i[l] = dout_i_q[l];
    assign dout_q[l] = dout_q_q[l];
  end

  assign valid_out = valid_q;
  assign blk_idx   = blk_q;
  assign frame_err = err_q;

endmodule

// File: doc/fft_input_packer.md
Name: fft_input_packer

Overview:
- Upstream neighbour of the FFT top.
- Accepts one complex <3.6> sample per cycle from the serial front end and collects FRAME_LEN samples into a ping-pong frame buffer.
- Replays each completed frame as a contiguous burst of FRAME_LEN/NUM beats. Each beat is NUM parallel lanes on din_i/din_q plus valid_in, the format the FFT consumes.
- Gapped or bursty serial input therefore always reaches the FFT as an unbroken 32-beat frame.

Parameters:
- IN_WIDTH, 9, sample width per component, signed <3.6>.
- NUM, 16, lanes per output beat.
- FRAME_LEN, 512, samples per FFT frame; must be a multiple of NUM. BLOCKS = FRAME_LEN/NUM = 32.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  serial sample valid.
- s_sof  in  1  start of frame; qualified by s_valid.
- s_i  in  IN_WIDTH  signed real sample.
- s_q  in  IN_WIDTH  signed imaginary sample.
- valid_out  out  1  beat valid; drives FFT valid_in.
- dout_i  out  IN_WIDTH x [0:NUM-1]  signed real lanes.
- dout_q  out  IN_WIDTH x [0:NUM-1]  signed imaginary lanes.
- blk_idx  out  5  row index of the current beat, 0..BLOCKS-1.
- frame_err  out  1  one-cycle pulse: partial frame discarded.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rstn).
- Reset values: valid_out=0, dout_i/dout_q all lanes 0, blk_idx=0, frame_err=0.
- Reset internal state: both banks EMPTY, write FSM in W_IDLE, write pointer 0, read FSM in R_IDLE.
- Reset asserted mid-frame or mid-burst forces all of the above immediately. The in-flight frame is lost.
- Storage: 2 banks x BLOCKS rows x NUM lanes x (2*IN_WIDTH) bits. Sample n of a frame goes to row n/NUM, lane n%NUM.
- Write FSM, W_IDLE:
  - s_valid && s_sof: write sample to wbank row0 lane0, wptr=1, go to W_FILL.
  - s_valid without s_sof: sample dropped silently.
- Write FSM, W_FILL:
  - Each s_valid && !s_sof writes at wptr, then wptr++.
  - s_valid low stalls; no data lost.
  - Sample at wptr=FRAME_LEN-1 is written, then wbank is marked FULL, wbank toggles, and the FSM returns to W_IDLE.
- Mid-frame s_sof (W_FILL, s_valid && s_sof):
  - frame_err pulses high for exactly one cycle.
  - The partial frame is discarded; the same bank is reused.
  - The sof sample is written as sample 0 and wptr=1.
- Read FSM, R_IDLE:
  - A FULL bank starts a burst on the next edge.
  - If both banks are FULL, the older one goes first.
- Read FSM, R_BURST: one row per cycle for BLOCKS consecutive cycles, no gaps. Then the bank is marked EMPTY and the FSM returns to R_IDLE.
- Latency:
  - The final sample of a frame is sampled at edge E. Row 0 is registered onto dout at edge E+1 with valid_out=1 and blk_idx=0.
  - Row r appears at edge E+1+r.
  - valid_out deasserts at edge E+1+BLOCKS.
- Lane mapping: at beat r, dout_i[l] and dout_q[l] carry sample NUM*r+l, copied verbatim with no scaling or sign change.
- Idle outputs: dout holds its last beat when valid_out=0; blk_idx returns to 0.
- Concurrency:
  - Write and read run in different banks simultaneously.
  - A burst takes 32 cycles and a refill takes at least 512, so the writer never reaches a FULL bank. No back-pressure port exists.
  - Two frames completing back-to-back produce two bursts separated by at least FRAME_LEN-BLOCKS idle cycles.
- No output depends combinationally on any input.

Test Plan:
- Ramp: reset, then 512 continuous samples s_i=n[8:0], s_q=~n[8:0], sof on n=0.
  -> valid_out high exactly 32 cycles, starting one edge after the last sample.
  -> Beat r: dout_i[l]=16r+l (mod 512, signed), blk_idx=r.
- Gapped input: the same ramp with s_valid toggling 1-of-3 cycles.
  -> Identical 32-beat burst with no gaps; timing referenced to the last accepted sample.
- Mid-frame sof: sof at n=0, 200 samples, then a new sof followed by 511 more samples.
  -> frame_err single pulse on the restart.
  -> Exactly one burst, whose beat 0 lane 0 is the second sof sample.
- Back-to-back frames: two 1024-sample continuous streams, sof every 512.
  -> Two bursts from alternating banks, each 32 beats, data matching its own frame.
  -> Write of frame 2 proceeds uninterrupted during burst 1.
- Stray data: s_valid without sof in W_IDLE for 100 cycles.
  -> No writes, no frame_err, valid_out stays 0.
- Reset mid-burst: assert rstn=0 at beat 10.
  -> valid_out and dout go to 0 immediately with no further beats.
  -> After release, a fresh frame produces a normal burst.
